lpc_synth: RTL and testbench
============================

// Module: lpc_synth
// PURPOSE
// LPC decoder / speech synthesiser on d_clk. Consumes one frame of predictor
// coefficients (A1..A10), voicing, pitch and gain; generates excitation (impulse
// train or LFSR noise). Runs it through a 10th-order all-pole lattice-free direct-form
// filter, one output sample per sample strobe. Single time-multiplexed MAC, one tap per cycle.
// PARAMETERS
// COEF_FRAC  12        coefficient fraction bits (Q3.12, 4096 = 1.0)
// ACC_W      40        accumulator width, signed
// LFSR_SEED  16'hACE1  noise LFSR reset value (must be non-zero)
// PORTS
// d_clk      in   1    clock
// rst        in   1    synchronous reset, active-high
// coef_load  in   1    strobe: capture A1..A10, voiced, pitch, gain into shadow regs
// A1..A10    in   16   signed predictor coefficients, Q3.12
// voiced     in   1    1 = impulse-train excitation, 0 = noise
// pitch      in   16   unsigned pitch period in samples
// gain       in   16   unsigned excitation amplitude (0..32767 used)
// v          in   1    sample strobe: request one output sample
// y          out  16   signed synthesised sample, valid when vout=1
// vout       out  1    one-cycle pulse, y valid
// busy       out  1    high while a sample is being computed
// overrun    out  1    one-cycle pulse when v arrives while busy (v dropped)
// BEHAVIOUR
// - Reset: y=0, vout=0, busy=0, overrun=0; history y[n-1..n-10]=0; active and
//   shadow coefs/gain=0, voiced=0, pitch=2; pitch counter=0; LFSR=LFSR_SEED; FSM=IDLE.
//   rst dominates everything, including mid-computation: no vout is issued.
// - coef_load: shadow regs updated any cycle. Shadow->active copy happens only in
//   IDLE on the cycle v is accepted, so a frame change never splits a sample.
//   If coef_load and v coincide, the new values are used for that sample.
// - FSM: IDLE -v-> EXC (1 cyc) -> MAC (10 cyc, k=1..10) -> OUT (1 cyc) -> IDLE.
//   busy=1 in EXC/MAC/OUT. vout asserted in OUT: 12 cycles after v sampled.
//   Back-to-back v is accepted on the cycle after OUT (sample rate <= d_clk/13).
// - v while busy: ignored, overrun pulses same cycle as v+1; state unaffected.
// - Excitation e (EXC state), 16-bit signed:
//   voiced: e = gain when pcnt==0 else 0; pcnt increments per accepted sample,
//   wraps to 0 after reaching P-1, P = max(pitch,2). If pitch changes so pcnt>=P,
//   pcnt wraps to 0 on that sample. Apply of voiced 0->1 clears pcnt to 0.
//   unvoiced: e = (signed(lfsr) * gain) >>> 15, floor.
//   LFSR: 16-bit Fibonacci, taps 16,14,13,11; shifts once per accepted sample
//   regardless of voicing; pcnt frozen while unvoiced.
// - Filter: acc = (e <<< COEF_FRAC) - sum_k A_k * y[n-k], ACC_W signed, exact.
//   y_new = acc >>> COEF_FRAC (floor), saturated to [-32768, 32767].
//   History shifts in OUT: y[n-1] <= y_new (saturated value stored).
// - A0 is not an input: leading coefficient fixed at 1.0.
// - Between OUT states y holds the last value; vout low.
// TESTING
// 1 Reset then v pulses, all coefs 0 -> vout 12 cyc after each v, y=0, LFSR=ACE1.
// 2 A1=-2048, voiced, pitch=4, gain=1000 -> y = 1000,500,250,125,1062,531.
// 3 A1=-8192, voiced, pitch=100, gain=30000 -> y = 30000, 32767, 32767 (saturate);
//   A1=+8192 pitch 100 gain 30000 -> y = 30000, -32768.
// 4 coef_load of new A1 during MAC -> current sample uses old A1; next uses new.
// 5 v asserted 5 cyc after accepted v -> overrun pulse, only one vout, busy unaffected.
// 6 Unvoiced, gain=32767, coefs 0 -> y equals LFSR sequence >>>15-scaled, matches
//   model; rst asserted mid-MAC -> no vout, y=0, history cleared.

Source files
------------

// File: rtl/lpc_synth.sv
// -----------------------------------------------------------------------------
// lpc_synth -- LPC speech synthesiser
//
// Purpose:
//   Holds one frame of 10 predictor coefficients plus voicing, pitch and gain,
//   and produces one synthesised sample per accepted sample strobe. Each sample
//   starts from an excitation (an impulse train when voiced, scaled LFSR noise
//   when unvoiced). That excitation drives a 10th-order direct-form all-pole
//   filter, evaluated with a single multiply-accumulate that handles one tap
//   per cycle.
//
// Ports:
//   d_clk      in   1   clock
//   rst        in   1   synchronous reset, active-high
//   coef_load  in   1   capture A1..A10, voiced, pitch, gain into shadow regs
//   A1..A10    in  16   signed predictor coefficients, Q3.12
//   voiced     in   1   1 = impulse-train excitation, 0 = noise
//   pitch      in  16   pitch period in samples (values below 2 act as 2)
//   gain       in  16   excitation amplitude (0..32767)
//   v          in   1   sample strobe
//   y          out 16   signed synthesised sample, valid with vout
//   vout       out  1   one-cycle pulse, y valid
//   busy       out  1   high while a sample is being computed
//   overrun    out  1   one-cycle pulse, a strobe arrived while busy (dropped)
//
// Timing: a strobe sampled in IDLE gives EXC (1) -> MAC (10) -> OUT (1).
// The result registers on the edge that leaves OUT, so vout is high 12 cycles
// after the edge that sampled v.
// -----------------------------------------------------------------------------
module lpc_synth #(
   parameter int          COEF_FRAC = 12,
   parameter int          ACC_W     = 40,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic               d_clk,
   input  logic               rst,
   input  logic               coef_load,
   input  logic signed [15:0] A1,
   input  logic signed [15:0] A2,
   input  logic signed [15:0] A3,
   input  logic signed [15:0] A4,
   input  logic signed [15:0] A5,
   input  logic signed [15:0] A6,
   input  logic signed [15:0] A7,
   input  logic signed [15:0] A8,
   input  logic signed [15:0] A9,
   input  logic signed [15:0] A10,
   input  logic               voiced,
   input  logic [15:0]        pitch,
   input  logic [15:0]        gain,
   input  logic               v,
   output logic signed [15:0] y,
   output logic               vout,
   output logic               busy,
   output logic               overrun
);

   typedef enum logic [1:0] {S_IDLE, S_EXC, S_MAC, S_OUT} state_t;

   state_t                   state_q;
   logic [3:0]               k_q;
   logic signed [ACC_W-1:0]  acc_q;
   logic signed [15:0]       hist_q     [10];
   logic signed [15:0]       sh_coef_q  [10];
   logic signed [15:0]       act_coef_q [10];
   logic                     sh_voiced_q, act_voiced_q;
   logic [15:0]              sh_pitch_q, act_pitch_q;
   logic [15:0]              sh_gain_q, act_gain_q;
   logic [15:0]              pcnt_q;
   logic [15:0]              lfsr_q;
   logic signed [15:0]       y_q;
   logic                     vout_q, busy_q, overrun_q;

   // Frame values seen on the cycle a strobe is accepted: a coef_load on that
   // same cycle takes precedence over the shadow registers.
   logic signed [15:0]       coef_in    [10];
   logic signed [15:0]       coef_src_d [10];
   logic                     voiced_src_d;
   logic [15:0]              pitch_src_d, gain_src_d;

   assign coef_in[0] = A1;
   assign coef_in[1] = A2;
   assign coef_in[2] = A3;
   assign coef_in[3] = A4;
   assign coef_in[4] = A5;
   assign coef_in[5] = A6;
   assign coef_in[6] = A7;
   assign coef_in[7] = A8;
   assign coef_in[8] = A9;
   assign coef_in[9] = A10;

   for (genvar gi = 0; gi < 10; gi++) begin : g_coef_src
      assign coef_src_d[gi] = coef_load ? coef_in[gi] : sh_coef_q[gi];
   end

   assign voiced_src_d = coef_load ? voiced : sh_voiced_q;
   assign pitch_src_d  = coef_load ? pitch  : sh_pitch_q;
   assign gain_src_d   = coef_load ? gain   : sh_gain_q;

   // ---------------- excitation ----------------
   logic [15:0]        p_eff_d, pcnt_eff_d, pcnt_next_d, lfsr_next_d;
   logic signed [32:0] lfsr_ext_d, gain_ext_d, noise_prod_d;
   logic signed [15:0] e_noise_d, e_d;

   assign p_eff_d     = (act_pitch_q < 16'd2) ? 16'd2 : act_pitch_q;
   // A pitch shrink that leaves the counter past the period restarts the cycle.
   assign pcnt_eff_d  = (pcnt_q >= p_eff_d) ? 16'd0 : pcnt_q;
   assign pcnt_next_d = (pcnt_eff_d == p_eff_d - 16'd1) ? 16'd0 : pcnt_eff_d + 16'd1;

   assign lfsr_next_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

   // Both operands widened to 33 bits so the product is exact; >>>15 floors.
   assign lfsr_ext_d   = {{17{lfsr_q[15]}}, lfsr_q};
   assign gain_ext_d   = {17'd0, act_gain_q};
   assign noise_prod_d = lfsr_ext_d * gain_ext_d;
   assign e_noise_d    = 16'(noise_prod_d >>> 15);

   assign e_d = act_voiced_q ? ((pcnt_eff_d == 16'd0) ? act_gain_q : 16'sd0) : e_noise_d;

   // ---------------- MAC datapath ----------------
   logic signed [31:0]      coef_ext_d, hist_ext_d, mac_prod_d;
   logic signed [ACC_W-1:0] acc_exc_d, acc_mac_d, acc_shift_d;
   logic                    in_range_d;
   logic signed [15:0]      y_sat_d;

   assign coef_ext_d = {{16{act_coef_q[k_q][15]}}, act_coef_q[k_q]};
   assign hist_ext_d = {{16{hist_q[k_q][15]}}, hist_q[k_q]};
   assign mac_prod_d = coef_ext_d * hist_ext_d;

   assign acc_exc_d = {{(ACC_W-16-COEF_FRAC){e_d[15]}}, e_d, {COEF_FRAC{1'b0}}};
   assign acc_mac_d = acc_q - {{(ACC_W-32){mac_prod_d[31]}}, mac_prod_d};

   // Floor to integer, then clamp: the value fits 16 bits only when every bit
   // from 15 upward equals the sign.
   assign acc_shift_d = acc_q >>> COEF_FRAC;
   assign in_range_d  = (&acc_shift_d[ACC_W-1:15]) | ~(|acc_shift_d[ACC_W-1:15]);
   assign y_sat_d     = in_range_d ? acc_shift_d[15:0]
                      : (acc_shift_d[ACC_W-1] ? 16'sh8000 : 16'sh7FFF);

   // ---------------- control FSM ----------------
   always_ff @(posedge d_clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         k_q          <= '0;
         acc_q        <= '0;
         pcnt_q       <= '0;
         lfsr_q       <= LFSR_SEED;
         y_q          <= '0;
         vout_q       <= 1'b0;
         busy_q       <= 1'b0;
         overrun_q    <= 1'b0;
         sh_voiced_q  <= 1'b0;
         act_voiced_q <= 1'b0;
         sh_pitch_q   <= 16'd2;
         act_pitch_q  <= 16'd2;
         sh_gain_q    <= '0;
         act_gain_q   <= '0;
         for (int i = 0; i < 10; i++) begin
            hist_q[i]     <= '0;
            sh_coef_q[i]  <= '0;
            act_coef_q[i] <= '0;
         end
      end else begin
         vout_q    <= 1'b0;
         overrun_q <= v && (state_q != S_IDLE);

         if (coef_load) begin
            for (int i = 0; i < 10; i++) sh_coef_q[i] <= coef_in[i];
            sh_voiced_q <= voiced;
            sh_pitch_q  <= pitch;
            sh_gain_q   <= gain;
         end

         case (state_q)
            S_IDLE: begin
               if (v) begin
                  for (int i = 0; i < 10; i++) act_coef_q[i] <= coef_src_d[i];
                  act_voiced_q <= voiced_src_d;
                  act_pitch_q  <= pitch_src_d;
                  act_gain_q   <= gain_src_d;
                  // Entering voiced mode starts a fresh pitch period.
                  if (voiced_src_d && !act_voiced_q) pcnt_q <= '0;
                  state_q <= S_EXC;
                  busy_q  <= 1'b1;
               end
            end
            S_EXC: begin
               acc_q  <= acc_exc_d;
               if (act_voiced_q) pcnt_q <= pcnt_next_d;
               lfsr_q <= lfsr_next_d;
               k_q    <= '0;
               state_q <= S_MAC;
            end
            S_MAC: begin
               acc_q <= acc_mac_d;
               k_q   <= k_q + 4'd1;
               if (k_q == 4'd9) state_q <= S_OUT;
            end
            S_OUT: begin
               y_q       <= y_sat_d;
               vout_q    <= 1'b1;
               hist_q[0] <= y_sat_d;
               for (int i = 1; i < 10; i++) hist_q[i] <= hist_q[i-1];
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign y       = y_q;
   assign vout    = vout_q;
   assign busy    = busy_q;
   assign overrun = overrun_q;

endmodule

// File: tb/tb_lpc_synth.sv
// -----------------------------------------------------------------------------
// tb_lpc_synth -- self-checking bench for lpc_synth
//
// Expected samples are pushed into a scoreboard queue when a strobe is driven
// and popped by a monitor when vout pulses (value and arrival cycle checked).
// A table covers the fixed-value sequences; hand-written sequences cover the
// mid-computation load, overrun, multi-tap filtering, noise and mid-MAC reset,
// using a small reference model where values are not simple constants.
// -----------------------------------------------------------------------------
module tb_lpc_synth;

   logic               d_clk = 1'b0;
   logic               rst, coef_load, voiced, v;
   logic [15:0]        pitch, gain;
   logic signed [15:0] a_in [10];
   logic signed [15:0] y;
   logic               vout, busy, overrun;

   always #5 d_clk = ~d_clk;

   lpc_synth dut (
      .d_clk(d_clk), .rst(rst), .coef_load(coef_load),
      .A1(a_in[0]), .A2(a_in[1]), .A3(a_in[2]), .A4(a_in[3]), .A5(a_in[4]),
      .A6(a_in[5]), .A7(a_in[6]), .A8(a_in[7]), .A9(a_in[8]), .A10(a_in[9]),
      .voiced(voiced), .pitch(pitch), .gain(gain), .v(v),
      .y(y), .vout(vout), .busy(busy), .overrun(overrun)
   );

   int cyc = 0;
   always @(posedge d_clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   typedef struct { longint y; int cyc; } exp_t;
   exp_t sb [$];
   exp_t mon_e;

   task automatic check(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Scoreboard consumer.
   always @(negedge d_clk) begin
      if (vout === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_vout actual=vout(y=%0d) required=none", y);
         end else begin
            mon_e = sb.pop_front();
            $display("sample y=%0d expected=%0d cycle=%0d", y, mon_e.y, cyc);
            check("sample_y", y, mon_e.y);
            check("vout_cycle", cyc, mon_e.cyc);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   longint     m_hist [10];
   longint     m_a [10], m_sa [10];
   bit         m_v, m_sv;
   longint     m_p, m_sp, m_g, m_sg, m_pcnt;
   logic [15:0] m_lfsr;

   function automatic void m_reset();
      for (int k = 0; k < 10; k++) begin
         m_hist[k] = 0; m_a[k] = 0; m_sa[k] = 0;
      end
      m_v = 0; m_sv = 0; m_p = 2; m_sp = 2; m_g = 0; m_sg = 0;
      m_pcnt = 0; m_lfsr = 16'hACE1;
   endfunction

   function automatic void m_load();
      for (int k = 0; k < 10; k++) m_sa[k] = a_in[k];
      m_sv = voiced; m_sp = pitch; m_sg = gain;
   endfunction

   function automatic longint m_sample();
      longint pp, e, acc, yn;
      if (m_sv && !m_v) m_pcnt = 0;
      m_a = m_sa; m_v = m_sv; m_p = m_sp; m_g = m_sg;
      if (m_v) begin
         pp = (m_p < 2) ? 2 : m_p;
         if (m_pcnt >= pp) m_pcnt = 0;
         e = (m_pcnt == 0) ? m_g : 0;
         m_pcnt++;
         if (m_pcnt == pp) m_pcnt = 0;
      end else begin
         e = (longint'($signed(m_lfsr)) * m_g) >>> 15;
      end
      m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
      acc = e * 4096;
      for (int k = 0; k < 10; k++) acc -= m_a[k] * m_hist[k];
      yn = acc >>> 12;
      if (yn > 32767)  yn = 32767;
      if (yn < -32768) yn = -32768;
      for (int k = 9; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = yn;
      return yn;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic do_reset();
      rst = 1'b1; v = 1'b0; coef_load = 1'b0;
      repeat (2) @(posedge d_clk);
      #1 rst = 1'b0;
      sb.delete();
   endtask

   task automatic send(input bit load, input longint exp_y);
      coef_load = load;
      v = 1'b1;
      sb.push_back('{exp_y, cyc + 13});
      @(posedge d_clk);
      #1 v = 1'b0;
      coef_load = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (sb.size() != 0 && n < 30) begin
         @(posedge d_clk);
         #1 n++;
      end
      check("sample_in_time", sb.size(), 0);
      sb.delete();
   endtask

   task automatic zero_coefs();
      for (int k = 0; k < 10; k++) a_in[k] = '0;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      bit                 do_rst;
      bit                 load;
      logic signed [15:0] a1;
      bit                 vcd;
      logic [15:0]        pitch;
      logic [15:0]        gain;
      longint             exp_y;
   } vec_t;

   function automatic vec_t mk(int r, int l, int a1, int vc, int p, int g, longint ey);
      vec_t t;
      t.do_rst = (r != 0); t.load = (l != 0); t.a1 = 16'(a1); t.vcd = (vc != 0);
      t.pitch = 16'(p); t.gain = 16'(g); t.exp_y = ey;
      return t;
   endfunction

   vec_t tbl [14];

   initial begin
      rst = 1'b1; coef_load = 1'b0; voiced = 1'b0; v = 1'b0;
      pitch = 16'd2; gain = 16'd0;
      zero_coefs();

      tbl[0]  = mk(1, 0,     0, 0,   2,     0,      0);
      tbl[1]  = mk(0, 0,     0, 0,   2,     0,      0);
      tbl[2]  = mk(0, 0,     0, 0,   2,     0,      0);
      tbl[3]  = mk(1, 1, -2048, 1,   4,  1000,   1000);
      tbl[4]  = mk(0, 0,     0, 0,   0,     0,    500);
      tbl[5]  = mk(0, 0,     0, 0,   0,     0,    250);
      tbl[6]  = mk(0, 0,     0, 0,   0,     0,    125);
      tbl[7]  = mk(0, 0,     0, 0,   0,     0,   1062);
      tbl[8]  = mk(0, 0,     0, 0,   0,     0,    531);
      tbl[9]  = mk(1, 1, -8192, 1, 100, 30000,  30000);
      tbl[10] = mk(0, 0,     0, 0,   0,     0,  32767);
      tbl[11] = mk(0, 0,     0, 0,   0,     0,  32767);
      tbl[12] = mk(1, 1,  8192, 1, 100, 30000,  30000);
      tbl[13] = mk(0, 0,     0, 0,   0,     0, -32768);

      do_reset();
      check("reset_y", y, 0);
      check("reset_vout", vout, 0);
      check("reset_busy", busy, 0);
      check("reset_overrun", overrun, 0);

      for (int i = 0; i < 14; i++) begin
         if (tbl[i].do_rst) do_reset();
         if (tbl[i].load) begin
            zero_coefs();
            a_in[0] = tbl[i].a1;
            voiced  = tbl[i].vcd;
            pitch   = tbl[i].pitch;
            gain    = tbl[i].gain;
         end
         send(tbl[i].load, tbl[i].exp_y);
         wait_done();
      end

      // coef_load during MAC: current sample keeps old A1, next uses new.
      do_reset();
      zero_coefs();
      a_in[0] = -16'sd2048; voiced = 1'b1; pitch = 16'd100; gain = 16'd1000;
      send(1'b1, 1000);
      wait_done();
      send(1'b0, 500);
      repeat (4) @(posedge d_clk);
      #1 a_in[0] = '0;
      coef_load = 1'b1;
      @(posedge d_clk);
      #1 coef_load = 1'b0;
      wait_done();
      send(1'b0, 0);
      wait_done();

      // Strobe while busy: overrun pulse, dropped, state unaffected.
      do_reset();
      zero_coefs();
      a_in[0] = -16'sd2048; voiced = 1'b1; pitch = 16'd100; gain = 16'd1000;
      send(1'b1, 1000);
      check("busy_after_accept", busy, 1);
      check("overrun_on_accept", overrun, 0);
      repeat (4) @(posedge d_clk);
      #1 v = 1'b1;
      @(posedge d_clk);
      #1 v = 1'b0;
      check("overrun_pulse", overrun, 1);
      check("busy_during_overrun", busy, 1);
      @(posedge d_clk);
      #1 check("overrun_one_cycle", overrun, 0);
      wait_done();
      check("busy_after_out", busy, 0);
      repeat (15) @(posedge d_clk);
      #1 send(1'b0, 500);
      wait_done();

      // All ten taps, pitch change forcing a counter wrap.
      do_reset();
      m_reset();
      a_in[0] = -16'sd3000; a_in[1] = 16'sd1500; a_in[2] = -16'sd800; a_in[3] = 16'sd400;
      a_in[4] = -16'sd200;  a_in[5] = 16'sd100;  a_in[6] = -16'sd50;  a_in[7] = 16'sd25;
      a_in[8] = -16'sd12;   a_in[9] = 16'sd6;
      voiced = 1'b1; pitch = 16'd3; gain = 16'd2000;
      m_load();
      send(1'b1, m_sample());
      wait_done();
      for (int i = 0; i < 7; i++) begin
         send(1'b0, m_sample());
         wait_done();
      end
      pitch = 16'd0;
      coef_load = 1'b1;
      m_load();
      @(posedge d_clk);
      #1 coef_load = 1'b0;
      for (int i = 0; i < 5; i++) begin
         send(1'b0, m_sample());
         wait_done();
      end

      // Unvoiced noise, then reset in the middle of a computation.
      do_reset();
      m_reset();
      zero_coefs();
      voiced = 1'b0; pitch = 16'd2; gain = 16'd32767;
      m_load();
      send(1'b1, m_sample());
      wait_done();
      for (int i = 0; i < 5; i++) begin
         send(1'b0, m_sample());
         wait_done();
      end
      v = 1'b1;
      @(posedge d_clk);
      #1 v = 1'b0;
      repeat (5) @(posedge d_clk);
      #1 rst = 1'b1;
      @(posedge d_clk);
      #1 rst = 1'b0;
      check("midrst_y", y, 0);
      check("midrst_busy", busy, 0);
      check("midrst_vout", vout, 0);
      repeat (15) @(posedge d_clk);
      #1 m_reset();
      a_in[0] = -16'sd2048; voiced = 1'b0; pitch = 16'd2; gain = 16'd0;
      m_load();
      send(1'b1, m_sample());
      wait_done();
      send(1'b0, m_sample());
      wait_done();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
